// File: rtl/dir_tracker_if.sv
// dir_tracker_if: sensor inputs, clear, and per-lane status/count outputs of dir_tracker.
interface dir_tracker_if #(
    parameter int CH = 2,
    parameter int CW = 8
);
    logic [CH-1:0]    e;
    logic [CH-1:0]    w;
    logic             clr;
    logic [CH-1:0]    idle;
    logic [CH-1:0]    pass_ew;
    logic [CH-1:0]    pass_we;
    logic [CH-1:0]    abort;
    logic [CH*CW-1:0] cnt_ew;
    logic [CH*CW-1:0] cnt_we;
    modport master(output e, w, clr, input idle, pass_ew, pass_we, abort, cnt_ew, cnt_we);
    modport slave(input e, w, clr, output idle, pass_ew, pass_we, abort, cnt_ew, cnt_we);
endinterface

// File: rtl/dir_tracker.sv
// dir_tracker: per-lane E/W pass detection with arm timeout, jam detection and
// saturating pass counters; every output comes from registered state.
module dir_tracker #(
    parameter int CH  = 2,
    parameter int CW  = 8,
    parameter int TMO = 16,
    parameter int TW  = 8
) (
    input logic         clk,
    input logic         rst_n,
    dir_tracker_if.slave sen
);
    typedef enum logic [2:0] {IDLE, ARM_E, ARM_W, CROSS_EW, CROSS_WE, JAM} state_t;
    localparam int unsigned TL = (TMO > 0) ? TMO - 1 : 0;
    for (genvar i = 0; i < CH; i++) begin : g_lane
        state_t        st_q, st_d;
        logic [TW-1:0] tmr_q, tmr_d;
        logic          pew_q, pew_d, pwe_q, pwe_d, ab_q, ab_d;
        logic [CW-1:0] cew_q, cew_d, cwe_q, cwe_d;
        logic          ei, wi, partner;
        assign ei = sen.e[i];
        assign wi = sen.w[i];
        assign partner = (st_q == ARM_E) ? wi : ei;
        always_comb begin
            st_d  = st_q;
            tmr_d = '0;
            pew_d = 1'b0;
            pwe_d = 1'b0;
            ab_d  = 1'b0;
            case (st_q)
                IDLE: st_d = (ei && wi) ? JAM : ei ? ARM_E : wi ? ARM_W : IDLE;
                ARM_E, ARM_W: begin
                    // the partner sensor beats a coincident timeout
                    if (partner) st_d = (st_q == ARM_E) ? CROSS_EW : CROSS_WE;
                    else if (TMO > 0 && tmr_q == TW'(TL)) begin
                        st_d = IDLE;
                        ab_d = 1'b1;
                    end else tmr_d = tmr_q + 1'b1;
                end
                CROSS_EW, CROSS_WE, JAM: if (!(ei || wi)) begin
                    st_d  = IDLE;
                    pew_d = st_q == CROSS_EW;
                    pwe_d = st_q == CROSS_WE;
                    ab_d  = st_q == JAM;
                end
                default: st_d = IDLE;
            endcase
            cew_d = sen.clr ? '0 : (pew_d && !(&cew_q)) ? cew_q + 1'b1 : cew_q;
            cwe_d = sen.clr ? '0 : (pwe_d && !(&cwe_q)) ? cwe_q + 1'b1 : cwe_q;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q  <= IDLE;
                tmr_q <= '0;
                pew_q <= 1'b0;
                pwe_q <= 1'b0;
                ab_q  <= 1'b0;
                cew_q <= '0;
                cwe_q <= '0;
            end else begin
                st_q  <= st_d;
                tmr_q <= tmr_d;
                pew_q <= pew_d;
                pwe_q <= pwe_d;
                ab_q  <= ab_d;
                cew_q <= cew_d;
                cwe_q <= cwe_d;
            end
        end
        assign sen.idle[i]              = st_q == IDLE;
        assign sen.pass_ew[i]           = pew_q;
        assign sen.pass_we[i]           = pwe_q;
        assign sen.abort[i]             = ab_q;
        assign sen.cnt_ew[i*CW +: CW]   = cew_q;
        assign sen.cnt_we[i*CW +: CW]   = cwe_q;
    end
endmodule

// File: tb/tb_dir_tracker.sv
// tb_dir_tracker: directed test-plan scenarios plus random sensor traffic,
// each cycle compared against a lane-level behavioural model.
module tb_dir_tracker;
    localparam int CH = 2, CW = 4, TMO = 8, CMAX = 15;
    logic clk = 0, rst_n = 0;
    int n_chk = 0, n_pass = 0;
    dir_tracker_if #(.CH(CH), .CW(CW)) bus ();
    dir_tracker #(.CH(CH), .CW(CW), .TMO(TMO), .TW(8)) dut (.clk(clk), .rst_n(rst_n), .sen(bus.slave));
    always #5 clk = ~clk;
    // model: which sensor tripped first (0 none, 1 east, 2 west, 3 both), whether
    // the second sensor has been seen, and edges spent waiting for it
    int first[CH], age[CH], c_ew[CH], c_we[CH];
    bit crossed[CH];
    logic [CH-1:0] m_pew, m_pwe, m_ab;
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < CH; i++) begin
            if (!rst_n) begin
                first[i] = 0; age[i] = 0; crossed[i] = 0; c_ew[i] = 0; c_we[i] = 0;
                m_pew[i] = 0; m_pwe[i] = 0; m_ab[i] = 0;
            end else begin
                bit ev, wv, quiet;
                ev = bus.e[i]; wv = bus.w[i]; quiet = !ev && !wv;
                m_pew[i] = 0; m_pwe[i] = 0; m_ab[i] = 0;
                if (first[i] == 0) begin
                    first[i] = (ev && wv) ? 3 : ev ? 1 : wv ? 2 : 0;
                    age[i] = 0;
                end else if (first[i] == 3) begin
                    if (quiet) begin first[i] = 0; m_ab[i] = 1; end
                end else if (crossed[i]) begin
                    if (quiet) begin
                        m_pew[i] = first[i] == 1;
                        m_pwe[i] = first[i] == 2;
                        first[i] = 0; crossed[i] = 0;
                    end
                end else if (first[i] == 1 ? wv : ev) crossed[i] = 1;
                else begin
                    age[i]++;
                    if (age[i] == TMO) begin first[i] = 0; m_ab[i] = 1; end
                end
                if (bus.clr) begin c_ew[i] = 0; c_we[i] = 0; end
                else begin
                    if (m_pew[i]) c_ew[i] = (c_ew[i] < CMAX) ? c_ew[i] + 1 : CMAX;
                    if (m_pwe[i]) c_we[i] = (c_we[i] < CMAX) ? c_we[i] + 1 : CMAX;
                end
            end
        end
    end
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask
    task automatic check_all();
        logic [CH-1:0] m_idle;
        for (int i = 0; i < CH; i++) m_idle[i] = first[i] == 0;
        check("idle", 32'(bus.idle), 32'(m_idle));
        check("pass_ew", 32'(bus.pass_ew), 32'(m_pew));
        check("pass_we", 32'(bus.pass_we), 32'(m_pwe));
        check("abort", 32'(bus.abort), 32'(m_ab));
        check("cnt_ew", 32'(bus.cnt_ew), {24'd0, 4'(c_ew[1]), 4'(c_ew[0])});
        check("cnt_we", 32'(bus.cnt_we), {24'd0, 4'(c_we[1]), 4'(c_we[0])});
    endtask
    task automatic drive(logic [CH-1:0] ev, logic [CH-1:0] wv, logic c = 1'b0);
        bus.e = ev; bus.w = wv; bus.clr = c;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask
    initial begin
        logic [CH-1:0] re, rw;
        bus.e = '0; bus.w = '0; bus.clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_idle", 32'(bus.idle), 32'h3);
        check("rst_cnt", 32'(bus.cnt_ew | bus.cnt_we), 32'h0);
        rst_n = 1;
        drive(2'b00, 2'b00);
        // lane0 minimum east-first pass
        drive(2'b01, 2'b00);
        drive(2'b01, 2'b01);
        drive(2'b00, 2'b00);
        check("t1_pulse", 32'(bus.pass_ew), 32'h1);
        check("t1_cnt", 32'(bus.cnt_ew), 32'h01);
        // lane1 west-only timeout, then partner on the timeout edge
        for (int k = 0; k < TMO + 1; k++) drive(2'b00, 2'b10);
        check("t2_abort", 32'(bus.abort), 32'h2);
        drive(2'b00, 2'b00);
        for (int k = 0; k < TMO; k++) drive(2'b00, 2'b10);
        drive(2'b10, 2'b10);
        check("t2_noabort", 32'({bus.abort[1], bus.idle[1]}), 32'h0);
        drive(2'b00, 2'b00);
        check("t2_pass", 32'(bus.pass_we), 32'h2);
        // jam on both lanes
        drive(2'b11, 2'b11);
        drive(2'b11, 2'b00);
        drive(2'b00, 2'b00);
        check("t3_abort", 32'(bus.abort), 32'h3);
        // saturation and clear-over-increment
        for (int k = 0; k < 17; k++) begin
            drive(2'b01, 2'b00);
            drive(2'b01, 2'b01);
            drive(2'b00, 2'b00);
        end
        check("t4_sat", 32'(bus.cnt_ew[3:0]), 32'd15);
        drive(2'b01, 2'b00);
        drive(2'b01, 2'b01);
        drive(2'b00, 2'b00, 1'b1);
        check("t4_clr", 32'({bus.pass_ew[0], bus.cnt_ew[3:0]}), 32'h10);
        // opposite passes finishing on the same edge
        drive(2'b01, 2'b10);
        drive(2'b11, 2'b11);
        drive(2'b00, 2'b00);
        check("t6_pulses", 32'({bus.pass_we, bus.pass_ew}), 32'b1001);
        check("t6_cnt", 32'({bus.cnt_we, bus.cnt_ew}), 32'h1001);
        // asynchronous reset mid-pass
        drive(2'b01, 2'b10);
        drive(2'b01, 2'b11);
        #2 rst_n = 0;
        #1;
        check("t5_idle", 32'(bus.idle), 32'h3);
        check("t5_cnt", 32'({bus.cnt_we, bus.cnt_ew}), 32'h0);
        bus.e = '0; bus.w = '0;
        @(negedge clk);
        rst_n = 1;
        drive(2'b00, 2'b00);
        drive(2'b00, 2'b00);
        // random traffic with held sensor levels so timeouts occur
        re = '0; rw = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < CH; i++) if ($urandom_range(0, 3) == 0) begin
                int r;
                r = $urandom_range(0, 9);
                re[i] = (r >= 4 && r <= 5) || r == 8;
                rw[i] = r >= 6;
            end
            drive(re, rw, $urandom_range(0, 31) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
